// File: rtl/bram_fifo_loader.sv
// bram_fifo_loader: walks addresses 0..NUM_WORDS-1 over two read-only BRAMs
// that share one address bus. For each word it adds the two read words,
// saturates the sum to the FIFO width, and writes it to a FIFO. The sequencer
// stalls while the FIFO is full. start, abort and done give the top level
// explicit control of a transfer.
// NUM_WORDS must lie in 1..2^ADDR_W. That keeps addr from wrapping.
module bram_fifo_loader #(
  parameter int ADDR_W    = 4,
  parameter int A_W       = 4,
  parameter int B_W       = 5,
  parameter int DOUT_W    = 5,
  parameter int NUM_WORDS = 10,
  parameter int RD_LAT    = 1
) (
  input  logic              fclk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  output logic [ADDR_W-1:0] addr,
  input  logic [A_W-1:0]    bram_a_dout,
  input  logic [B_W-1:0]    bram_b_dout,
  output logic [DOUT_W-1:0] fifo_din,
  output logic              fifo_wr_en,
  input  logic              fifo_full,
  output logic              busy,
  output logic              done,
  output logic              sat_flag,
  output logic [ADDR_W:0]   word_cnt
);

  // The sum is one bit wider than the wider operand. The compare width also
  // covers DOUT_W, so the saturation threshold is always representable.
  localparam int SUM_W = ((A_W > B_W) ? A_W : B_W) + 1;
  localparam int CMP_W = ((SUM_W > DOUT_W) ? SUM_W : DOUT_W) + 1;
  localparam logic [CMP_W-1:0]  DOUT_MAX = CMP_W'((64'd1 << DOUT_W) - 64'd1);
  localparam logic [ADDR_W:0]   LAST_CNT = NUM_WORDS[ADDR_W:0];
  localparam logic [1:0]        LAT_LAST = 2'(RD_LAT - 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W + 1)'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADDR  = 3'd1,
    S_WAIT  = 3'd2,
    S_HOLD  = 3'd3,
    S_WRITE = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [1:0]          lat_q, lat_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DOUT_W-1:0]   fifo_din_q, fifo_din_d;
  logic                fifo_wr_en_q, fifo_wr_en_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                sat_flag_q, sat_flag_d;
  logic [ADDR_W:0]     word_cnt_q, word_cnt_d;
  logic [SUM_W-1:0]    sum_s;

  function automatic logic [SUM_W-1:0] add_words(input logic [A_W-1:0] a,
                                                 input logic [B_W-1:0] b);
    return SUM_W'(a) + SUM_W'(b);
  endfunction

  function automatic logic sum_overflows(input logic [SUM_W-1:0] s);
    return CMP_W'(s) > DOUT_MAX;
  endfunction

  function automatic logic [DOUT_W-1:0] sat_word(input logic [SUM_W-1:0] s);
    if (sum_overflows(s)) begin
      return {DOUT_W{1'b1}};
    end else begin
      return DOUT_W'(s);
    end
  endfunction

  assign sum_s = add_words(bram_a_dout, bram_b_dout);

  // Compute the next state and all next output values. abort overrides every
  // other transition.
  always_comb begin
    state_d      = state_q;
    lat_d        = lat_q;
    addr_d       = addr_q;
    fifo_din_d   = fifo_din_q;
    fifo_wr_en_d = 1'b0;
    done_d       = 1'b0;
    sat_flag_d   = sat_flag_q;
    word_cnt_d   = word_cnt_q;
    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      addr_d  = {ADDR_W{1'b0}};
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start && !abort) begin
            state_d    = S_ADDR;
            addr_d     = {ADDR_W{1'b0}};
            word_cnt_d = {(ADDR_W + 1){1'b0}};
            sat_flag_d = 1'b0;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_ADDR: begin
          state_d = S_WAIT;
          lat_d   = 2'd0;
        end
        S_WAIT: begin
          if (lat_q == LAT_LAST) begin
            state_d    = S_HOLD;
            fifo_din_d = sat_word(sum_s);
            sat_flag_d = sat_flag_q | sum_overflows(sum_s);
          end else begin
            lat_d = lat_q + 2'd1;
          end
        end
        S_HOLD: begin
          // The strobe is registered here, so it is high during the WRITE
          // state itself.
          if (!fifo_full) begin
            state_d      = S_WRITE;
            fifo_wr_en_d = 1'b1;
            word_cnt_d   = word_cnt_q + CNT_ONE;
          end else begin
            state_d = S_HOLD;
          end
        end
        S_WRITE: begin
          if (word_cnt_q == LAST_CNT) begin
            state_d = S_IDLE;
            addr_d  = {ADDR_W{1'b0}};
            done_d  = 1'b1;
          end else begin
            state_d = S_ADDR;
            addr_d  = addr_q + ADDR_ONE;
          end
        end
        default: begin
          state_d = S_IDLE;
          addr_d  = {ADDR_W{1'b0}};
        end
      endcase
    end
    busy_d = (state_d != S_IDLE);
  end

  // Register the state and all outputs. Reset is asynchronous and active-low.
  always_ff @(posedge fclk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      lat_q        <= 2'd0;
      addr_q       <= {ADDR_W{1'b0}};
      fifo_din_q   <= {DOUT_W{1'b0}};
      fifo_wr_en_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      sat_flag_q   <= 1'b0;
      word_cnt_q   <= {(ADDR_W + 1){1'b0}};
    end else begin
      state_q      <= state_d;
      lat_q        <= lat_d;
      addr_q       <= addr_d;
      fifo_din_q   <= fifo_din_d;
      fifo_wr_en_q <= fifo_wr_en_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      sat_flag_q   <= sat_flag_d;
      word_cnt_q   <= word_cnt_d;
    end
  end

  assign addr       = addr_q;
  assign fifo_din   = fifo_din_q;
  assign fifo_wr_en = fifo_wr_en_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign sat_flag   = sat_flag_q;
  assign word_cnt   = word_cnt_q;

endmodule

// File: tb/tb_bram_fifo_loader.sv
// Testbench for bram_fifo_loader. It drives two instances, one with RD_LAT=1
// and one with RD_LAT=2, from behavioural BRAM models. Every FIFO write is
// compared against sums computed from the memory contents, and against the
// cycle positions derived from the word spacing.
module tb_bram_fifo_loader;

  localparam int NUM  = 10;
  localparam int DMAX = 31;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  logic reset_n, start_drv, abort_drv, fifo_full, sel;
  logic start1, start2, abort1, abort2;
  logic [3:0] mem_a [16];
  logic [4:0] mem_b [16];

  logic [3:0] addr1, addr2, a1, a2, a2p;
  logic [4:0] b1, b2, b2p, din1, din2, cnt1, cnt2;
  logic       wr1, wr2, busy1, busy2, done1, done2, sat1, sat2;

  logic [3:0] o_addr;
  logic [4:0] o_din, o_cnt;
  logic       o_wr, o_busy, o_done, o_sat;

  assign start1 = start_drv & ~sel;
  assign start2 = start_drv & sel;
  assign abort1 = abort_drv & ~sel;
  assign abort2 = abort_drv & sel;

  assign o_addr = sel ? addr2 : addr1;
  assign o_din  = sel ? din2  : din1;
  assign o_cnt  = sel ? cnt2  : cnt1;
  assign o_wr   = sel ? wr2   : wr1;
  assign o_busy = sel ? busy2 : busy1;
  assign o_done = sel ? done2 : done1;
  assign o_sat  = sel ? sat2  : sat1;

  // BRAM models: one register stage for the RD_LAT=1 instance, two for RD_LAT=2.
  always @(posedge clk) begin
    a1  <= mem_a[addr1];
    b1  <= mem_b[addr1];
    a2p <= mem_a[addr2];
    b2p <= mem_b[addr2];
    a2  <= a2p;
    b2  <= b2p;
  end

  bram_fifo_loader u_dut1 (
    .fclk(clk), .reset(reset_n), .start(start1), .abort(abort1),
    .addr(addr1), .bram_a_dout(a1), .bram_b_dout(b1),
    .fifo_din(din1), .fifo_wr_en(wr1), .fifo_full(fifo_full),
    .busy(busy1), .done(done1), .sat_flag(sat1), .word_cnt(cnt1)
  );

  bram_fifo_loader #(.RD_LAT(2)) u_dut2 (
    .fclk(clk), .reset(reset_n), .start(start2), .abort(abort2),
    .addr(addr2), .bram_a_dout(a2), .bram_b_dout(b2),
    .fifo_din(din2), .fifo_wr_en(wr2), .fifo_full(fifo_full),
    .busy(busy2), .done(done2), .sat_flag(sat2), .word_cnt(cnt2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference: the word written for index i is A+B clipped to the FIFO maximum.
  function automatic int raw_sum(input int i);
    return int'(mem_a[i]) + int'(mem_b[i]);
  endfunction

  function automatic int model_word(input int i);
    return (raw_sum(i) > DMAX) ? DMAX : raw_sum(i);
  endfunction

  task automatic load_mem(input int mode);
    for (int i = 0; i < 16; i++) begin
      if (mode == 2) begin
        mem_a[i] = 4'($urandom_range(0, 15));
        mem_b[i] = 5'($urandom_range(0, 31));
      end else begin
        mem_a[i] = 4'(i);
        mem_b[i] = 5'(2 * i);
      end
    end
    if (mode == 1) begin
      mem_a[2] = 4'd15;
      mem_b[2] = 5'd31;
    end
  endtask

  task automatic start_pulse(output int s);
    @(negedge clk);
    start_drv = 1'b1;
    @(negedge clk);
    start_drv = 1'b0;
    s = cyc;
  endtask

  // Follow one transfer. full_mode: 0 = never full, 1 = 22-cycle stall ahead
  // of word 3, 2 = random full. restart_after / abort_after (-1 = unused) give
  // the number of writes completed before start is pulsed (in ADDR) or abort
  // is raised (in WAIT).
  task automatic watch(input int lat, input bit timed, input int full_mode,
                       input int restart_after, input int abort_after, input int s);
    int  n_wr = 0;
    int  n_done = 0;
    int  last_wr = s;
    int  stall_left = 0;
    int  exp_cnt;
    bit  sat_m = 1'b0;
    bit  fin = 1'b0;
    bit  quiet_wr = 1'b0;
    bit  quiet_done = 1'b0;
    exp_cnt = (abort_after >= 0) ? abort_after : NUM;
    for (int c = 0; c < 3000 && !fin; c++) begin
      @(negedge clk);
      if (start_drv) start_drv = 1'b0;
      if (abort_drv) begin
        abort_drv = 1'b0;
        chk("abort_busy", 32'(o_busy), 0);
        chk("abort_addr", 32'(o_addr), 0);
        fin = 1'b1;
      end
      if (o_wr) begin
        chk("wr_while_full", 32'(fifo_full), 0);
        chk("wr_data", 32'(o_din), model_word(n_wr));
        chk("wr_addr", 32'(o_addr), n_wr);
        if (raw_sum(n_wr) > DMAX) sat_m = 1'b1;
        chk("wr_sat", 32'(o_sat), 32'(sat_m));
        chk("wr_cnt", 32'(o_cnt), n_wr + 1);
        if (timed) chk("wr_cycle", cyc, s + (lat + 3) * (n_wr + 1) - 1);
        n_wr++;
        last_wr = cyc;
      end
      if (o_done) begin
        n_done++;
        chk("done_with_busy", 32'(o_busy), 0);
        if (timed) chk("done_cycle", cyc, s + (lat + 3) * NUM);
        fin = 1'b1;
      end
      case (full_mode)
        1: begin
          if (o_wr && n_wr == 3) stall_left = 22;
          fifo_full = (stall_left > 0);
          if (stall_left > 0) stall_left--;
        end
        2: fifo_full = ($urandom_range(0, 2) == 0);
        default: fifo_full = 1'b0;
      endcase
      if (restart_after >= 0 && n_wr == restart_after && cyc == last_wr + 1) start_drv = 1'b1;
      if (abort_after >= 0 && n_wr == abort_after && cyc == last_wr + 2) abort_drv = 1'b1;
    end
    fifo_full = 1'b0;
    chk("xfer_finished", 32'(fin), 1);
    chk("n_writes", n_wr, exp_cnt);
    chk("n_done", n_done, (abort_after >= 0) ? 0 : 1);
    chk("final_cnt", 32'(o_cnt), exp_cnt);
    chk("final_sat", 32'(o_sat), 32'(sat_m));
    for (int c = 0; c < 2 * (lat + 3) + 3; c++) begin
      @(negedge clk);
      if (o_wr) quiet_wr = 1'b1;
      if (o_done) quiet_done = 1'b1;
    end
    chk("quiet_wr", 32'(quiet_wr), 0);
    chk("quiet_done", 32'(quiet_done), 0);
    chk("quiet_cnt", 32'(o_cnt), exp_cnt);
  endtask

  initial begin
    int s;
    int nw;
    reset_n   = 1'b0;
    start_drv = 1'b0;
    abort_drv = 1'b0;
    fifo_full = 1'b0;
    sel       = 1'b0;
    load_mem(0);
    repeat (3) @(negedge clk);

    // Reset state of both instances.
    for (int k = 0; k < 2; k++) begin
      sel = (k == 1);
      #1;
      chk("rst_addr", 32'(o_addr), 0);
      chk("rst_din", 32'(o_din), 0);
      chk("rst_wr", 32'(o_wr), 0);
      chk("rst_busy", 32'(o_busy), 0);
      chk("rst_done", 32'(o_done), 0);
      chk("rst_sat", 32'(o_sat), 0);
      chk("rst_cnt", 32'(o_cnt), 0);
    end
    sel = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Basic transfer with RD_LAT=1.
    load_mem(0);
    start_pulse(s);
    watch(1, 1'b1, 0, -1, -1, s);

    // Saturation on word 2.
    load_mem(1);
    start_pulse(s);
    watch(1, 1'b1, 0, -1, -1, s);

    // Backpressure stall ahead of word 3. sat_flag must clear on start.
    load_mem(0);
    start_pulse(s);
    watch(1, 1'b0, 1, -1, -1, s);

    // start while busy is ignored; abort in the WAIT of word 6.
    start_pulse(s);
    watch(1, 1'b1, 0, 5, 6, s);

    // start and abort together in IDLE: abort wins.
    @(negedge clk);
    start_drv = 1'b1;
    abort_drv = 1'b1;
    @(negedge clk);
    start_drv = 1'b0;
    abort_drv = 1'b0;
    chk("start_abort_busy", 32'(o_busy), 0);
    @(negedge clk);
    chk("start_abort_busy2", 32'(o_busy), 0);

    // Asynchronous reset while stalled in HOLD of word 4.
    start_pulse(s);
    nw = 0;
    for (int c = 0; c < 200 && nw < 4; c++) begin
      @(negedge clk);
      if (o_wr) nw++;
    end
    fifo_full = 1'b1;
    repeat (4) @(negedge clk);
    chk("pre_rst_busy", 32'(o_busy), 1);
    chk("pre_rst_cnt", 32'(o_cnt), 4);
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_addr", 32'(o_addr), 0);
    chk("async_rst_din", 32'(o_din), 0);
    chk("async_rst_busy", 32'(o_busy), 0);
    chk("async_rst_cnt", 32'(o_cnt), 0);
    chk("async_rst_wr", 32'(o_wr), 0);
    @(negedge clk);
    reset_n   = 1'b1;
    fifo_full = 1'b0;
    start_pulse(s);
    watch(1, 1'b1, 0, -1, -1, s);

    // RD_LAT=2 instance: 5-cycle spacing.
    sel = 1'b1;
    load_mem(0);
    start_pulse(s);
    watch(2, 1'b1, 0, -1, -1, s);

    // Random data with random backpressure on both latencies.
    for (int r = 0; r < 6; r++) begin
      sel = (r % 2 == 1);
      load_mem(2);
      start_pulse(s);
      watch(sel ? 2 : 1, 1'b0, 2, -1, -1, s);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
